dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each transaction walks IDLE -> ISSUE -> CAPTURE -> DONE, one cycle per state.
module dmem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_wren,
  input  logic [11:0] p_addr,
  input  logic [31:0] p_data,
  output logic        p_ack,
  output logic [31:0] p_q,
  input  logic        d_req,
  input  logic        d_wren,
  input  logic [11:0] d_addr,
  input  logic [31:0] d_data,
  output logic        d_ack,
  output logic [31:0] d_q,
  output logic [11:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t state;
  logic   owner_d;       // 1 = debug port owns the current transaction
  logic   last_grant_d;  // 1 = debug port won the most recent grant
  logic   lat_wren;
  logic   pick_d;

  // Debug wins when it is the only requester, or when both request and
  // the processor was served last.
  always_comb begin
    pick_d = d_req & (~p_req | ~last_grant_d);
  end

  // NOTE: all state and outputs are registered with non-blocking assignments
  // so every output is a clean flop and there is no ordering hazard between them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b1;
      lat_wren     <= 1'b0;
      address_dmem <= '0;
      data         <= '0;
      wren         <= 1'b0;
      p_ack        <= 1'b0;
      d_ack        <= 1'b0;
      p_q          <= '0;
      d_q          <= '0;
      grant        <= 2'b00;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p_req || d_req) begin
            owner_d      <= pick_d;
            last_grant_d <= pick_d;
            lat_wren     <= pick_d ? d_wren : p_wren;
            wren         <= pick_d ? d_wren : p_wren;
            address_dmem <= pick_d ? d_addr : p_addr;
            data         <= pick_d ? d_data : p_data;
            grant        <= pick_d ? 2'b10 : 2'b01;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wren  <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          // Memory read data is valid during this cycle, one clock after the address.
          if (!lat_wren) begin
            if (owner_d) d_q <= q_dmem;
            else         p_q <= q_dmem;
          end
          p_ack <= ~owner_d;
          d_ack <= owner_d;
          state <= DONE;
        end
        DONE: begin
          p_ack <= 1'b0;
          d_ack <= 1'b0;
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural one-cycle-latency memory plus
// hand-computed expectations checked with immediate assertions.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p_req = 1'b0, p_wren = 1'b0;
  logic [11:0] p_addr = '0;
  logic [31:0] p_data = '0;
  logic        p_ack;
  logic [31:0] p_q;
  logic        d_req = 1'b0, d_wren = 1'b0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_data = '0;
  logic        d_ack;
  logic [31:0] d_q;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem = '0;
  logic [1:0]  grant;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .p_ack(p_ack), .p_q(p_q),
    .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_data(d_data),
    .d_ack(d_ack), .d_q(d_q),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  // Memory model: unwritten words read back as 0xA5000000 | address.
  logic [31:0] mem [4096];
  bit          written [4096];
  always @(posedge clock) begin
    if (wren) begin
      mem[address_dmem]     <= data;
      written[address_dmem] <= 1'b1;
    end
    q_dmem <= written[address_dmem] ? mem[address_dmem] : {20'hA5000, address_dmem};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int p_cnt, d_cnt, overlap;

  initial begin
    // Reset held low with both ports requesting: everything stays at reset values.
    p_req = 1'b1; d_req = 1'b1; p_wren = 1'b1; d_wren = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_wren", wren, 0);
    check("rst_addr", address_dmem, 0);
    check("rst_data", data, 0);
    check("rst_acks", {p_ack, d_ack}, 0);
    check("rst_pq", p_q, 0);
    check("rst_dq", d_q, 0);
    p_req = 1'b0; d_req = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Processor write 0xDEADBEEF to 0x010.
    p_req = 1'b1; p_wren = 1'b1; p_addr = 12'h010; p_data = 32'hDEADBEEF;
    tick();
    p_req = 1'b0;
    check("wr_issue_grant", grant, 2'b01);
    check("wr_issue_busy", busy, 1);
    check("wr_issue_wren", wren, 1);
    check("wr_issue_addr", address_dmem, 12'h010);
    check("wr_issue_data", data, 32'hDEADBEEF);
    tick();
    check("wr_capture_wren", wren, 0);
    check("wr_capture_addr", address_dmem, 12'h010);
    check("wr_capture_ack", p_ack, 0);
    tick();
    check("wr_done_pack", p_ack, 1);
    check("wr_done_dack", d_ack, 0);
    check("wr_done_pq", p_q, 0);
    tick();
    check("wr_idle_pack", p_ack, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_idle_grant", grant, 0);
    check("wr_idle_addr_hold", address_dmem, 12'h010);
    check("wr_idle_data_hold", data, 32'hDEADBEEF);

    // Processor read-back of 0x010.
    p_req = 1'b1; p_wren = 1'b0;
    tick();
    p_req = 1'b0;
    check("rd_issue_wren", wren, 0);
    check("rd_issue_grant", grant, 2'b01);
    tick();
    check("rd_capture_wren", wren, 0);
    tick();
    check("rd_done_pack", p_ack, 1);
    check("rd_done_pq", p_q, 32'hDEADBEEF);
    tick();

    // Brief reset clears read data; then both ports contend.
    reset = 1'b0;
    tick();
    check("rst2_pq", p_q, 0);
    reset = 1'b1;
    p_req = 1'b1; p_addr = 12'h001;
    d_req = 1'b1; d_wren = 1'b0; d_addr = 12'h002;
    tick();
    p_req = 1'b0;
    check("sim_first_grant", grant, 2'b01);
    tick(); tick();
    check("sim_p_ack", {p_ack, d_ack}, 2'b10);
    check("sim_p_q", p_q, 32'hA5000001);
    tick();
    check("sim_gap_grant", grant, 0);
    tick();
    d_req = 1'b0;
    check("sim_second_grant", grant, 2'b10);
    tick(); tick();
    check("sim_d_ack", {p_ack, d_ack}, 2'b01);
    check("sim_d_q", d_q, 32'hA5000002);
    check("sim_p_q_hold", p_q, 32'hA5000001);
    tick();

    // Continuous contention for eight transactions; last grant was debug.
    p_req = 1'b1; p_addr = 12'h003;
    d_req = 1'b1; d_addr = 12'h004;
    p_cnt = 0; d_cnt = 0; overlap = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k % 4 == 0)
        check($sformatf("rr_grant_%0d", k / 4), grant, ((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
      if (p_ack) p_cnt++;
      if (d_ack) d_cnt++;
      if (p_ack && d_ack) overlap++;
    end
    p_req = 1'b0; d_req = 1'b0;
    check("rr_p_acks", p_cnt, 4);
    check("rr_d_acks", d_cnt, 4);
    check("rr_overlap", overlap, 0);
    check("rr_p_q", p_q, 32'hA5000003);
    check("rr_d_q", d_q, 32'hA5000004);
    tick();
    check("rr_idle_busy", busy, 0);

    // Mid-flight changes during CAPTURE are ignored.
    p_req = 1'b1; p_wren = 1'b0; p_addr = 12'h020;
    tick();
    check("mid_issue_grant", grant, 2'b01);
    tick();
    p_req = 1'b0; p_addr = 12'h3FF; p_wren = 1'b1; p_data = 32'h0BADF00D;
    tick();
    check("mid_done_addr", address_dmem, 12'h020);
    check("mid_done_pack", p_ack, 1);
    check("mid_done_pq", p_q, 32'hA5000020);
    check("mid_done_wren", wren, 0);
    tick();
    check("mid_idle_pack", p_ack, 0);
    tick();
    check("mid_no_regrant", busy, 0);
    check("mid_mem_3ff_untouched", {31'd0, written[12'h3FF]}, 0);

    // Reset during ISSUE of a debug write aborts it.
    d_req = 1'b1; d_wren = 1'b1; d_addr = 12'h055; d_data = 32'h12345678;
    tick();
    check("abort_issue_grant", grant, 2'b10);
    check("abort_issue_wren", wren, 1);
    reset = 1'b0; d_req = 1'b0;
    tick();
    check("abort_wren", wren, 0);
    check("abort_busy", busy, 0);
    check("abort_grant", grant, 0);
    check("abort_dq", d_q, 0);
    check("abort_dack", d_ack, 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("abort_no_dack_%0d", k), d_ack, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
